// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter
//   Writeback scheduler in front of the reorder buffer's single slot-write
//   path. Completions from the ALU (port 1), MUL (port 2) and LD/ST (port 3)
//   units are each held in a one-entry buffer. Every cycle the valid buffer
//   whose ROB id is oldest relative to the ROB head is presented to the ROB.
//   Ports whose buffer is still occupied are backpressured.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   head                current ROB head (oldest id)
//   flush               discard all buffered completions
//   port1/2_*           register-writing completions (id, address, data, w, req)
//   port3_*             LD/ST completions (id, address, data, s, req)
//   portN_stall         completion not accepted this cycle
//   wb_*                write request to the ROB; all fields zero when idle
//   wb_stall            ROB cannot take the write this cycle
//
// Build option
//   WB_PIPE_EN          adds a registered output stage (2-cycle latency)

module rob_wb_arbiter #(
  parameter int ID_SIZE          = 1,
  parameter int REGISTER_SIZE    = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int ADDRESS_SIZE     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_SIZE-1:0]          head,
  input  logic                        flush,

  input  logic [ID_SIZE-1:0]          port1_id,
  input  logic [REG_ADDRESS_SIZE-1:0] port1_address,
  input  logic [REGISTER_SIZE-1:0]    port1_data,
  input  logic                        port1_w,
  input  logic                        port1_req,
  output logic                        port1_stall,

  input  logic [ID_SIZE-1:0]          port2_id,
  input  logic [REG_ADDRESS_SIZE-1:0] port2_address,
  input  logic [REGISTER_SIZE-1:0]    port2_data,
  input  logic                        port2_w,
  input  logic                        port2_req,
  output logic                        port2_stall,

  input  logic [ID_SIZE-1:0]          port3_id,
  input  logic [ADDRESS_SIZE-1:0]     port3_address,
  input  logic [REGISTER_SIZE-1:0]    port3_data,
  input  logic                        port3_s,
  input  logic                        port3_req,
  output logic                        port3_stall,

  output logic [ID_SIZE-1:0]          wb_id,
  output logic [ADDRESS_SIZE-1:0]     wb_address,
  output logic [REGISTER_SIZE-1:0]    wb_data,
  output logic                        wb_w,
  output logic                        wb_m,
  output logic                        wb_req,
  input  logic                        wb_stall
);

  localparam int NP = 3;

  // Incoming completions normalised to the ROB write format, so the buffers
  // and the selector treat all three ports identically.
  logic [ID_SIZE-1:0]       in_id   [NP];
  logic [ADDRESS_SIZE-1:0]  in_addr [NP];
  logic [REGISTER_SIZE-1:0] in_data [NP];
  logic [NP-1:0]            in_w;
  logic [NP-1:0]            in_m;
  logic [NP-1:0]            in_req;

  always_comb begin
    in_id[0]   = port1_id;
    in_addr[0] = ADDRESS_SIZE'(port1_address);
    in_data[0] = port1_data;
    in_w[0]    = port1_w;
    in_m[0]    = 1'b0;
    in_req[0]  = port1_req;

    in_id[1]   = port2_id;
    in_addr[1] = ADDRESS_SIZE'(port2_address);
    in_data[1] = port2_data;
    in_w[1]    = port2_w;
    in_m[1]    = 1'b0;
    in_req[1]  = port2_req;

    in_id[2]   = port3_id;
    in_addr[2] = port3_address;
    in_data[2] = port3_data;
    in_w[2]    = ~port3_s;
    in_m[2]    = port3_s;
    in_req[2]  = port3_req;
  end

  // One-entry buffer per port
  logic [NP-1:0]            val_q,  val_d;
  logic [ID_SIZE-1:0]       id_q   [NP];
  logic [ID_SIZE-1:0]       id_d   [NP];
  logic [ADDRESS_SIZE-1:0]  addr_q [NP];
  logic [ADDRESS_SIZE-1:0]  addr_d [NP];
  logic [REGISTER_SIZE-1:0] data_q [NP];
  logic [REGISTER_SIZE-1:0] data_d [NP];
  logic [NP-1:0]            w_q, w_d;
  logic [NP-1:0]            m_q, m_d;

  // Selector: smallest (id - head) mod 2^ID_SIZE wins; strict compare in
  // ascending port order gives ties to the lower port number.
  logic [ID_SIZE-1:0]       age [NP];
  logic                     sel_valid;
  logic [NP-1:0]            sel_onehot;
  logic [ID_SIZE-1:0]       sel_age;
  logic [ID_SIZE-1:0]       sel_id;
  logic [ADDRESS_SIZE-1:0]  sel_addr;
  logic [REGISTER_SIZE-1:0] sel_data;
  logic                     sel_w;
  logic                     sel_m;

  always_comb begin
    sel_valid  = 1'b0;
    sel_onehot = '0;
    sel_age    = '0;
    sel_id     = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_w      = 1'b0;
    sel_m      = 1'b0;
    for (int i = 0; i < NP; i++) begin
      age[i] = id_q[i] - head;
      if (val_q[i] && (!sel_valid || (age[i] < sel_age))) begin
        sel_valid  = 1'b1;
        sel_onehot = NP'(1) << i;
        sel_age    = age[i];
        sel_id     = id_q[i];
        sel_addr   = addr_q[i];
        sel_data   = data_q[i];
        sel_w      = w_q[i];
        sel_m      = m_q[i];
      end
    end
  end

  // sel_take: the selected buffer is emptied at this edge
  logic          sel_take;
  logic [NP-1:0] consumed;
  logic [NP-1:0] stall;
  logic [NP-1:0] accept;

`ifdef WB_PIPE_EN
  logic                     ov_q,    ov_d;
  logic [ID_SIZE-1:0]       oid_q,   oid_d;
  logic [ADDRESS_SIZE-1:0]  oaddr_q, oaddr_d;
  logic [REGISTER_SIZE-1:0] odata_q, odata_d;
  logic                     ow_q,    ow_d;
  logic                     om_q,    om_d;

  // The stage refills when empty or when its current write retires.
  assign sel_take = sel_valid && (!ov_q || !wb_stall);

  always_comb begin
    ov_d    = ov_q;
    oid_d   = oid_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    ow_d    = ow_q;
    om_d    = om_q;
    if (flush) begin
      ov_d    = 1'b0;
      oid_d   = '0;
      oaddr_d = '0;
      odata_d = '0;
      ow_d    = 1'b0;
      om_d    = 1'b0;
    end else if (sel_take) begin
      ov_d    = 1'b1;
      oid_d   = sel_id;
      oaddr_d = sel_addr;
      odata_d = sel_data;
      ow_d    = sel_w;
      om_d    = sel_m;
    end else if (ov_q && !wb_stall) begin
      // Clear the fields too so the outputs read zero while idle.
      ov_d    = 1'b0;
      oid_d   = '0;
      oaddr_d = '0;
      odata_d = '0;
      ow_d    = 1'b0;
      om_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q    <= 1'b0;
      oid_q   <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
      ow_q    <= 1'b0;
      om_q    <= 1'b0;
    end else begin
      ov_q    <= ov_d;
      oid_q   <= oid_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      ow_q    <= ow_d;
      om_q    <= om_d;
    end
  end

  assign wb_req     = ov_q;
  assign wb_id      = oid_q;
  assign wb_address = oaddr_q;
  assign wb_data    = odata_q;
  assign wb_w       = ow_q;
  assign wb_m       = om_q;
`else
  assign sel_take   = sel_valid && !wb_stall;

  assign wb_req     = sel_valid;
  assign wb_id      = sel_id;
  assign wb_address = sel_addr;
  assign wb_data    = sel_data;
  assign wb_w       = sel_w;
  assign wb_m       = sel_m;
`endif

  assign consumed = sel_take ? sel_onehot : '0;
  assign stall    = val_q & ~consumed;
  assign accept   = in_req & ~stall & {NP{~flush}};

  assign port1_stall = stall[0];
  assign port2_stall = stall[1];
  assign port3_stall = stall[2];

  // A consumed buffer may reload in the same cycle and then stays valid.
  always_comb begin
    val_d = val_q;
    w_d   = w_q;
    m_d   = m_q;
    for (int i = 0; i < NP; i++) begin
      id_d[i]   = id_q[i];
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (flush) begin
        val_d[i] = 1'b0;
      end else if (accept[i]) begin
        val_d[i]  = 1'b1;
        id_d[i]   = in_id[i];
        addr_d[i] = in_addr[i];
        data_d[i] = in_data[i];
        w_d[i]    = in_w[i];
        m_d[i]    = in_m[i];
      end else if (consumed[i]) begin
        val_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      w_q   <= '0;
      m_q   <= '0;
      for (int i = 0; i < NP; i++) begin
        id_q[i]   <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      w_q   <= w_d;
      m_q   <= m_d;
      for (int i = 0; i < NP; i++) begin
        id_q[i]   <= id_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
module tb_rob_wb_arbiter;

  localparam int IDW = 2;
  localparam int RW  = 32;
  localparam int RAW = 5;
  localparam int AW  = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [IDW-1:0] head;
  logic           flush;
  logic [IDW-1:0] port1_id, port2_id, port3_id;
  logic [RAW-1:0] port1_address, port2_address;
  logic [AW-1:0]  port3_address;
  logic [RW-1:0]  port1_data, port2_data, port3_data;
  logic           port1_w, port2_w, port3_s;
  logic           port1_req, port2_req, port3_req;
  logic           port1_stall, port2_stall, port3_stall;
  logic [IDW-1:0] wb_id;
  logic [AW-1:0]  wb_address;
  logic [RW-1:0]  wb_data;
  logic           wb_w, wb_m, wb_req;
  logic           wb_stall;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_wb_arbiter #(
    .ID_SIZE(IDW), .REGISTER_SIZE(RW), .REG_ADDRESS_SIZE(RAW), .ADDRESS_SIZE(AW)
  ) dut (
    .clk(clk), .reset(reset), .head(head), .flush(flush),
    .port1_id(port1_id), .port1_address(port1_address), .port1_data(port1_data),
    .port1_w(port1_w), .port1_req(port1_req), .port1_stall(port1_stall),
    .port2_id(port2_id), .port2_address(port2_address), .port2_data(port2_data),
    .port2_w(port2_w), .port2_req(port2_req), .port2_stall(port2_stall),
    .port3_id(port3_id), .port3_address(port3_address), .port3_data(port3_data),
    .port3_s(port3_s), .port3_req(port3_req), .port3_stall(port3_stall),
    .wb_id(wb_id), .wb_address(wb_address), .wb_data(wb_data),
    .wb_w(wb_w), .wb_m(wb_m), .wb_req(wb_req), .wb_stall(wb_stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // wb write as {req, id, w, m, data}
  function automatic logic [63:0] wb_pack();
    return {27'd0, wb_req, 2'(wb_id), wb_w, wb_m, wb_data};
  endfunction

  function automatic logic [63:0] exp_wb(input logic r, input logic [1:0] id,
                                        input logic w, input logic m, input logic [31:0] d);
    return {27'd0, r, id, w, m, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; wb_stall = 0;
    port1_req = 0; port2_req = 0; port3_req = 0;
    port1_id = 0; port2_id = 0; port3_id = 0;
    port1_address = 0; port2_address = 0; port3_address = 0;
    port1_data = 0; port2_data = 0; port3_data = 0;
    port1_w = 0; port2_w = 0; port3_s = 0;
  endtask

  initial begin
    idle_inputs();
    head = 0;
    reset = 1;
    step(); step();
    reset = 0;

    // Reset state
    mid();
    chk("rst_wb", wb_pack(), 64'd0);
    chk("rst_addr", 64'(wb_address), 64'd0);
    chk("rst_stalls", {61'd0, port1_stall, port2_stall, port3_stall}, 64'd0);
    step();

`ifdef WB_PIPE_EN
    // Single completion, 2-cycle latency
    port1_req = 1; port1_id = 1; port1_data = 32'hAA; port1_w = 1;
    mid();
    chk("p_lat_c0", 64'(wb_req), 64'd0);
    step();
    port1_req = 0;
    mid();
    chk("p_lat_c1", 64'(wb_req), 64'd0);
    step();
    mid();
    chk("p_lat_c2", wb_pack(), exp_wb(1, 1, 1, 0, 32'hAA));
    step();
    mid();
    chk("p_lat_c3", wb_pack(), 64'd0);
    step();

    // Back-to-back: one write per cycle, no bubble
    for (int i = 0; i < 4; i++) begin
      port1_req = 1; port1_id = 2'(i); port1_data = 32'h100 + 32'(i); port1_w = 1;
      mid();
      chk("p_b2b_stall", 64'(port1_stall), 64'd0);
      if (i >= 2) chk("p_b2b_wb", wb_pack(), exp_wb(1, 2'(i - 2), 1, 0, 32'h100 + 32'(i - 2)));
      step();
    end
    port1_req = 0;
    for (int i = 2; i < 4; i++) begin
      mid();
      chk("p_b2b_tail", wb_pack(), exp_wb(1, 2'(i), 1, 0, 32'h100 + 32'(i)));
      step();
    end
    mid();
    chk("p_b2b_idle", 64'(wb_req), 64'd0);
    step();
`else
    // Single completion, 1-cycle latency
    port1_req = 1; port1_id = 1; port1_data = 32'hAA; port1_w = 1; port1_address = 5'd7;
    mid();
    chk("s2_stall", 64'(port1_stall), 64'd0);
    chk("s2_pre", 64'(wb_req), 64'd0);
    step();
    idle_inputs();
    mid();
    chk("s2_wb", wb_pack(), exp_wb(1, 1, 1, 0, 32'hAA));
    chk("s2_addr", 64'(wb_address), 64'd7);
    step();
    mid();
    chk("s2_after", wb_pack(), 64'd0);
    step();

    // Age ordering with wrap-around: head=3, ages p3=0, p2=1, p1=3
    head = 3;
    port1_req = 1; port1_id = 2; port1_data = 32'h11; port1_w = 1; port1_address = 5'd1;
    port2_req = 1; port2_id = 0; port2_data = 32'h22; port2_w = 1; port2_address = 5'd2;
    port3_req = 1; port3_id = 3; port3_data = 32'h33; port3_s = 1; port3_address = 32'h1000;
    step();
    port3_req = 0;
    mid();
    chk("s3_g1", wb_pack(), exp_wb(1, 3, 0, 1, 32'h33));
    chk("s3_g1_addr", 64'(wb_address), 64'h1000);
    chk("s3_redrive_stall", {62'd0, port1_stall, port2_stall}, 64'b11);
    step();
    port1_req = 0; port2_req = 0;
    mid();
    chk("s3_g2", wb_pack(), exp_wb(1, 0, 1, 0, 32'h22));
    chk("s3_g2_stall", {62'd0, port1_stall, port2_stall}, 64'b10);
    step();
    mid();
    chk("s3_g3", wb_pack(), exp_wb(1, 2, 1, 0, 32'h11));
    step();
    mid();
    chk("s3_done", 64'(wb_req), 64'd0);
    step();

    // Equal age: lower port wins
    head = 0;
    port1_req = 1; port1_id = 1; port1_data = 32'h51; port1_w = 0;
    port2_req = 1; port2_id = 1; port2_data = 32'h52; port2_w = 1;
    step();
    idle_inputs();
    mid();
    chk("tie_g1", wb_pack(), exp_wb(1, 1, 0, 0, 32'h51));
    step();
    mid();
    chk("tie_g2", wb_pack(), exp_wb(1, 1, 1, 0, 32'h52));
    step();

    // ROB backpressure with port2 held
    port2_req = 1; port2_id = 1; port2_data = 32'h11; port2_w = 1;
    step();
    port2_data = 32'h22;
    wb_stall = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("s4_hold_wb", wb_pack(), exp_wb(1, 1, 1, 0, 32'h11));
      chk("s4_hold_stall", 64'(port2_stall), 64'd1);
      step();
    end
    wb_stall = 0;
    mid();
    chk("s4_rel_wb", wb_pack(), exp_wb(1, 1, 1, 0, 32'h11));
    chk("s4_rel_stall", 64'(port2_stall), 64'd0);
    step();
    port2_req = 0;
    mid();
    chk("s4_new_wb", wb_pack(), exp_wb(1, 1, 1, 0, 32'h22));
    step();
    mid();
    chk("s4_idle", 64'(wb_req), 64'd0);
    step();

    // Flush drops two buffered entries and a request made during flush
    port1_req = 1; port1_id = 1; port1_data = 32'h61; port1_w = 1;
    port3_req = 1; port3_id = 2; port3_data = 32'h63; port3_s = 0;
    step();
    idle_inputs();
    flush = 1; wb_stall = 1;
    port2_req = 1; port2_id = 3; port2_data = 32'h62; port2_w = 1;
    mid();
    chk("s5_flush_stall", {61'd0, port1_stall, port2_stall, port3_stall}, 64'b101);
    step();
    idle_inputs();
    mid();
    chk("s5_after_wb", wb_pack(), 64'd0);
    chk("s5_after_stall", {61'd0, port1_stall, port2_stall, port3_stall}, 64'd0);
    step();

    // Reset mid-operation drops a buffered completion
    port3_req = 1; port3_id = 1; port3_data = 32'h77; port3_s = 1;
    step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    mid();
    chk("rst_mid_wb", wb_pack(), 64'd0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
